// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and display-layout helpers for lcd_writer.
package lcd_pkg;

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_SNAP, ST_PASS} wr_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_E_HI, TX_WAIT} tx_state_t;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [4:0] LAST_INIT_STEP = 5'd3;
  localparam logic [4:0] LAST_PASS_STEP = 5'd16;

  function automatic logic [7:0] init_byte(input logic [4:0] step);
    case (step)
      5'd0:    return FUNC_SET;
      5'd1:    return DISP_ON;
      5'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

  // Returns {rs, data} for one refresh step; s[k] is the character at bits [8k+7:8k].
  function automatic logic [8:0] pass_byte(input logic [4:0] step, input logic [87:0] s);
    logic [8:0] b;
    b = {1'b1, SPACE};
    case (step)
      5'd0:  b = {1'b0, LINE1};
      5'd1:  b = {1'b1, s[47:40]};
      5'd2:  b = {1'b1, s[39:32]};
      5'd3:  b = {1'b1, COLON};
      5'd4:  b = {1'b1, s[31:24]};
      5'd5:  b = {1'b1, s[23:16]};
      5'd6:  b = {1'b1, COLON};
      5'd7:  b = {1'b1, s[15:8]};
      5'd8:  b = {1'b1, s[7:0]};
      5'd9:  b = {1'b1, SPACE};
      5'd10: b = {1'b1, s[87:80]};
      5'd11: b = {1'b0, LINE2};
      5'd12: b = {1'b1, s[79:72]};
      5'd13: b = {1'b1, s[71:64]};
      5'd14: b = {1'b1, SLASH};
      5'd15: b = {1'b1, s[63:56]};
      5'd16: b = {1'b1, s[55:48]};
      default: b = {1'b1, SPACE};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 write: SETUP for a cycle, E high, then a settle wait; done pulses on the last wait cycle.
module lcd_byte_tx #(
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);
  import lcd_pkg::*;

  localparam int MAX_A   = (E_PULSE_CYCLES > CMD_WAIT_CYCLES) ? E_PULSE_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_CYC = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

  tx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          rs_reg, rs_next;
  logic [7:0]    data_reg, data_next;
  logic          long_reg, long_next;
  logic [CW-1:0] wait_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
      long_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
      long_reg  <= long_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    long_next  = long_reg;
    done       = 1'b0;
    wait_last  = long_reg ? CLEAR_LAST : CMD_LAST;
    case (state_reg)
      TX_IDLE: begin
        if (start) begin
          state_next = TX_SETUP;
          rs_next    = rs;
          data_next  = data;
          long_next  = long_wait;
        end
      end
      TX_SETUP: begin
        state_next = TX_E_HI;
        cnt_next   = '0;
      end
      TX_E_HI: begin
        if (cnt_reg == E_LAST) begin
          state_next = TX_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TX_WAIT: begin
        if (cnt_reg == wait_last) begin
          done = 1'b1;
          // A start on the last wait cycle chains the next byte with no gap.
          if (start) begin
            state_next = TX_SETUP;
            rs_next    = rs;
            data_next  = data;
            long_next  = long_wait;
          end else begin
            state_next = TX_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign lcd_e    = (state_reg == TX_E_HI);
  assign lcd_rs   = rs_reg;
  assign lcd_data = data_reg;

endmodule

// File: rtl/lcd_writer.sv
// HD44780 writer: power-up init, then snapshot-and-refresh passes of "HH:MM:SS X" / "MM/DD".
// Define LCD_CHANGE_DETECT_EN to also start a pass whenever lcd_value differs from the last snapshot.
module lcd_writer #(
  parameter int POWERUP_CYCLES    = 2000000,
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [87:0] lcd_value,
  input  logic        refresh,
  output logic        busy,
  output logic        init_done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);
  import lcd_pkg::*;

  localparam int PW = $clog2(POWERUP_CYCLES + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);

  wr_state_t     state_reg, state_next;
  logic [PW-1:0] pwr_cnt_reg, pwr_cnt_next;
  logic [4:0]    step_reg, step_next, step_inc;
  logic          pending_reg, pending_next;
  logic [87:0]   snapshot_reg, snapshot_next;
  logic          init_done_reg, init_done_next;
  logic          tx_start, tx_rs, tx_long, tx_done;
  logic [7:0]    tx_data;
  logic          changed;

`ifdef LCD_CHANGE_DETECT_EN
  assign changed = (lcd_value != snapshot_reg);
`else
  assign changed = 1'b0;
`endif

  assign step_inc  = step_reg + 5'd1;
  assign busy      = (state_reg != ST_IDLE);
  assign init_done = init_done_reg;
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_PWRUP;
      pwr_cnt_reg   <= '0;
      step_reg      <= '0;
      pending_reg   <= 1'b0;
      snapshot_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pwr_cnt_reg   <= pwr_cnt_next;
      step_reg      <= step_next;
      pending_reg   <= pending_next;
      snapshot_reg  <= snapshot_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pwr_cnt_next   = pwr_cnt_reg;
    step_next      = step_reg;
    snapshot_next  = snapshot_reg;
    init_done_next = init_done_reg;
    tx_start       = 1'b0;
    tx_rs          = 1'b0;
    tx_data        = 8'h00;
    tx_long        = 1'b0;
    // Requests arriving while busy collapse into a single pending pass.
    pending_next   = pending_reg;
    if (refresh && busy)
      pending_next = 1'b1;
    else if (state_reg == ST_SNAP)
      pending_next = 1'b0;

    case (state_reg)
      ST_PWRUP: begin
        if (pwr_cnt_reg == PWR_LAST) begin
          state_next   = ST_INIT;
          pwr_cnt_next = '0;
          step_next    = '0;
          tx_start     = 1'b1;
          tx_data      = init_byte(5'd0);
        end else begin
          pwr_cnt_next = pwr_cnt_reg + 1'b1;
        end
      end
      ST_INIT: begin
        if (tx_done) begin
          if (step_reg == LAST_INIT_STEP) begin
            step_next      = '0;
            init_done_next = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            step_next = step_inc;
            tx_start  = 1'b1;
            tx_data   = init_byte(step_inc);
            tx_long   = (step_inc == LAST_INIT_STEP);
          end
        end
      end
      ST_IDLE: begin
        if (refresh || pending_reg || changed)
          state_next = ST_SNAP;
      end
      ST_SNAP: begin
        snapshot_next     = lcd_value;
        step_next         = '0;
        tx_start          = 1'b1;
        {tx_rs, tx_data}  = pass_byte(5'd0, lcd_value);
        state_next        = ST_PASS;
      end
      ST_PASS: begin
        if (tx_done) begin
          if (step_reg == LAST_PASS_STEP) begin
            step_next  = '0;
            state_next = ST_IDLE;
          end else begin
            step_next        = step_inc;
            tx_start         = 1'b1;
            {tx_rs, tx_data} = pass_byte(step_inc, snapshot_reg);
          end
        end
      end
      default: state_next = ST_PWRUP;
    endcase
  end

  lcd_byte_tx #(
    .E_PULSE_CYCLES   (E_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .rs       (tx_rs),
    .data     (tx_data),
    .long_wait(tx_long),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: timeline model of init and refresh passes checked every cycle, plus literal pins.
module tb_lcd_writer;
  localparam int P   = 10;
  localparam int EP  = 2;
  localparam int CWT = 4;
  localparam int CLW = 8;
  localparam int BYTE_LEN = 1 + EP + CWT;
  localparam int CLR_LEN  = 1 + EP + CLW;
  localparam int INIT_LEN = 3 * BYTE_LEN + CLR_LEN;
  localparam int PASS_LEN = 1 + 17 * BYTE_LEN;
`ifdef LCD_CHANGE_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        refresh;
  logic [87:0] lcd_value;
  logic        busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] bus_log[$];

  lcd_writer #(
    .POWERUP_CYCLES   (P),
    .E_PULSE_CYCLES   (EP),
    .CMD_WAIT_CYCLES  (CWT),
    .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_value(lcd_value),
    .refresh  (refresh),
    .busy     (busy),
    .init_done(init_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef enum {M_PWR, M_INIT, M_IDLE, M_PASS} seg_t;
  seg_t        seg = M_PWR;
  int          seg_start = 0;
  logic        pend = 1'b0;
  logic [87:0] snap = '0;
  logic        last_rs = 1'b0;
  logic [7:0]  last_data = 8'h00;
  logic        done_m = 1'b0;
  logic [8:0]  plist [17];
  logic [7:0]  init_list [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  function automatic logic [7:0] chr(input logic [87:0] v, input int k);
    return v[8*k +: 8];
  endfunction

  // Display text: line 1 "HH:MM:SS X", line 2 "MM/DD", each preceded by its cursor command.
  task automatic make_pass_list(input logic [87:0] v);
    logic [7:0] line1 [10];
    logic [7:0] line2 [5];
    line1 = '{chr(v,5), chr(v,4), 8'h3A, chr(v,3), chr(v,2), 8'h3A, chr(v,1), chr(v,0), 8'h20, chr(v,10)};
    line2 = '{chr(v,9), chr(v,8), 8'h2F, chr(v,7), chr(v,6)};
    plist[0] = {1'b0, 8'h80};
    for (int i = 0; i < 10; i++) plist[1+i] = {1'b1, line1[i]};
    plist[11] = {1'b0, 8'hC0};
    for (int i = 0; i < 5; i++) plist[12+i] = {1'b1, line2[i]};
  endtask

  initial begin
    int pos, idx, ph;
    logic xe, xrs, xbusy, xdone, prev_e;
    logic [7:0] xdata;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_lcd_e", 32'(lcd_e), 32'(0));
        chk("rst_lcd_rs", 32'(lcd_rs), 32'(0));
        chk("rst_lcd_data", 32'(lcd_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_init_done", 32'(init_done), 32'(0));
        seg = M_PWR; seg_start = cyc + 1; pend = 1'b0; snap = '0;
        last_rs = 1'b0; last_data = 8'h00; done_m = 1'b0; prev_e = 1'b0;
      end else begin
        pos = cyc - seg_start;
        xe = 1'b0; xrs = last_rs; xdata = last_data; xbusy = 1'b1; xdone = done_m;
        case (seg)
          M_PWR: begin
            pend = pend | refresh;
            if (pos == P - 1) begin seg = M_INIT; seg_start = cyc + 1; end
          end
          M_INIT: begin
            if (pos < 3 * BYTE_LEN) begin idx = pos / BYTE_LEN; ph = pos % BYTE_LEN; end
            else begin idx = 3; ph = pos - 3 * BYTE_LEN; end
            xe = (ph >= 1 && ph <= EP); xrs = 1'b0; xdata = init_list[idx];
            pend = pend | refresh;
            if (pos == INIT_LEN - 1) begin seg = M_IDLE; seg_start = cyc + 1; done_m = 1'b1; end
          end
          M_IDLE: begin
            xbusy = 1'b0;
            if (refresh || pend || (CD && lcd_value != snap)) begin seg = M_PASS; seg_start = cyc + 1; end
          end
          M_PASS: begin
            if (pos == 0) begin
              snap = lcd_value; make_pass_list(lcd_value); pend = refresh;
            end else begin
              idx = (pos - 1) / BYTE_LEN; ph = (pos - 1) % BYTE_LEN;
              xe = (ph >= 1 && ph <= EP); {xrs, xdata} = plist[idx];
              pend = pend | refresh;
              if (pos == PASS_LEN - 1) begin seg = M_IDLE; seg_start = cyc + 1; end
            end
          end
          default: ;
        endcase
        last_rs = xrs; last_data = xdata;
        chk("lcd_e", 32'(lcd_e), 32'(xe));
        chk("lcd_rs", 32'(lcd_rs), 32'(xrs));
        chk("lcd_data", 32'(lcd_data), 32'(xdata));
        chk("lcd_rw", 32'(lcd_rw), 32'(0));
        chk("busy", 32'(busy), 32'(xbusy));
        chk("init_done", 32'(init_done), 32'(xdone));
        if (lcd_e && !prev_e) bus_log.push_back({lcd_rs, lcd_data});
        prev_e = lcd_e;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick(1);
    refresh = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 2000) begin
      if (!busy && init_done) quiet++; else quiet = 0;
      tick(1);
      n++;
    end
    chk(name, 32'({busy, init_done}), 32'(1));
  endtask

  task automatic count_busy(input int max, output int n);
    n = 0;
    while (busy && n < max) begin n++; tick(1); end
  endtask

  task automatic check_log(input string name, input logic [8:0] exp [17], input int cnt);
    logic [8:0] act;
    chk({name, "_count"}, 32'(bus_log.size()), 32'(cnt));
    for (int i = 0; i < cnt; i++) begin
      act = (i < bus_log.size()) ? bus_log[i] : 9'h1FF;
      chk($sformatf("%s[%0d]", name, i), 32'(act), 32'(exp[i]));
    end
  endtask

  initial begin
    int n;
    logic [8:0]  exp_init [17];
    logic [8:0]  exp2 [17];
    logic [87:0] v2;
    exp_init = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0,
                 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    exp2 = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h133, 9'h134, 9'h13A, 9'h135, 9'h136,
             9'h120, 9'h154, 9'h0C0, 9'h130, 9'h137, 9'h12F, 9'h130, 9'h134};
    v2 = "T0704123456";
    rst_n = 1'b0; refresh = 1'b0; lcd_value = '0;
    tick(3);
    chk("reset_busy", 32'(busy), 32'(1));
    chk("reset_init_done", 32'(init_done), 32'(0));
    chk("reset_lcd_e", 32'(lcd_e), 32'(0));
    chk("reset_lcd_data", 32'(lcd_data), 32'(0));
    bus_log.delete();
    rst_n = 1'b1;

    // Power-up wait then the four init commands; init_done lands 10+21+11 cycles after release.
    n = 0;
    while (!init_done && n < 200) begin tick(1); n++; end
    chk("init_done_latency", 32'(n), 32'(42));
    check_log("init_bytes", exp_init, 4);

    // One refresh: 120 busy cycles and the expected 17 bus bytes.
    lcd_value = v2; bus_log.delete();
    pulse_refresh();
    count_busy(1000, n);
    chk("pass_busy_cycles", 32'(n), 32'(PASS_LEN));
    check_log("pass_bytes", exp2, 17);

    // Three refreshes during a pass merge into exactly one follow-on pass.
    pulse_refresh();
    n = 0;
    while (busy && n < 1000) begin
      refresh = (n == 20 || n == 50 || n == 90);
      tick(1);
      n++;
    end
    refresh = 1'b0;
    chk("merge_first_pass", 32'(n), 32'(PASS_LEN));
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("merge_gap", 32'(n), 32'(1));
    count_busy(1000, n);
    chk("merge_second_pass", 32'(n), 32'(PASS_LEN));
    n = 0;
    repeat (150) begin if (busy) n++; tick(1); end
    chk("merge_no_third", 32'(n), 32'(0));

    // lcd_value changed mid-pass: remaining bytes still come from the snapshot.
    bus_log.delete();
    pulse_refresh();
    tick(40);
    lcd_value = "X1231235959";
    count_busy(1000, n);
    chk("midpass_busy_rest", 32'(n), 32'(PASS_LEN - 40));
    check_log("midpass_bytes", exp2, 17);
    wait_idle("midpass_idle");

    // Reset during E high of a pass byte: E drops at once, then power-up and init repeat.
    pulse_refresh();
    tick(37);
    chk("byte5_e_high", 32'(lcd_e), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lcd_e", 32'(lcd_e), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(1));
    chk("async_rst_init_done", 32'(init_done), 32'(0));
    tick(2);
    bus_log.delete();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 200) begin tick(1); n++; end
    chk("reinit_latency", 32'(n), 32'(42));
    check_log("reinit_bytes", exp_init, 4);
    wait_idle("reinit_idle");

`ifdef LCD_CHANGE_DETECT_EN
    // Seconds tick with no refresh starts one pass showing the new seconds digit.
    lcd_value = v2;
    wait_idle("cd_settle");
    bus_log.delete();
    lcd_value = "T0704123457";
    n = 0;
    while (!busy && n < 10) begin tick(1); n++; end
    chk("cd_pass_start", 32'(n), 32'(1));
    count_busy(1000, n);
    chk("cd_pass_busy", 32'(n), 32'(PASS_LEN));
    exp2[8] = 9'h137;
    check_log("cd_bytes", exp2, 17);
    n = 0;
    repeat (150) begin if (busy) n++; tick(1); end
    chk("cd_stable_no_pass", 32'(n), 32'(0));
`else
    // Without change detection a new lcd_value alone never starts a pass.
    lcd_value = "T0704123457";
    n = 0;
    repeat (150) begin if (busy) n++; tick(1); end
    chk("no_cd_no_pass", 32'(n), 32'(0));
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
